switch_nport: RTL

SWITCH_NPORT -- requirements
Module: switch_nport

---
 rtl/switch_nport_pkg.sv | 10 +
 rtl/switch_rr_arb.sv | 39 +++
 rtl/switch_nport.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/switch_nport_pkg.sv
// Shared constants for the N-port packet switch: default geometry and drop-counter sizing.
package switch_nport_pkg;

  localparam int unsigned NUM_PORTS_DEF  = 4;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned CNT_W          = 8;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

endpackage

// File: rtl/switch_rr_arb.sv
// Round-robin arbiter for one output port; the search starts at ptr_q and ptr_q moves past
// the winner.
module switch_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin : p_arb
    int unsigned idx;
    idx   = 0;
    gnt   = '0;
    ptr_d = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        ptr_d    = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_ptr
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/switch_nport.sv
// N-port switch: one FIFO per input, per-head remaining-target mask, one round-robin
// arbiter per output and registered output slices.
module switch_nport
  import switch_nport_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           valid_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] source_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] target_in,
  input  logic [NUM_PORTS*DATA_W-1:0]    data_in,
  output logic [NUM_PORTS-1:0]           in_ready,
  output logic [NUM_PORTS-1:0]           valid_out,
  output logic [NUM_PORTS*NUM_PORTS-1:0] source_out,
  output logic [NUM_PORTS*NUM_PORTS-1:0] target_out,
  output logic [NUM_PORTS*DATA_W-1:0]    data_out,
  output logic [NUM_PORTS*CNT_W-1:0]     drop_cnt
);

  localparam int unsigned N  = NUM_PORTS;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef logic [N-1:0] mask_t;
  typedef logic [AW:0]  cnt_t;

  cnt_t              cnt_q   [N];
  logic [AW-1:0]     rd_q    [N];
  logic [AW-1:0]     wr_q    [N];
  mask_t             rem_q   [N];
  mask_t             rem_d   [N];
  mask_t             mem_src [N][FIFO_DEPTH];
  mask_t             mem_tgt [N][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_dat [N][FIFO_DEPTH];
  logic [CNT_W-1:0]  drop_q  [N];
  logic              run_q;
  logic [N-1:0]      push, pop, drop, nonempty;
  mask_t             req [N];
  mask_t             gnt [N];
  mask_t             hit [N];
  logic [N-1:0]      vo_d, vo_q;
  mask_t             so_d [N], so_q [N], to_d [N], to_q [N];
  logic [DATA_W-1:0] do_d [N], do_q [N];

  // run_q keeps the first edge after reset release free of pushes and drops.
  always_comb begin : p_fifo_ctl
    nonempty = '0;
    in_ready = '0;
    push     = '0;
    drop     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      nonempty[i] = cnt_q[i] != '0;
      in_ready[i] = cnt_q[i] != cnt_t'(FIFO_DEPTH);
      push[i]     = run_q && valid_in[i] && in_ready[i] && (target_in[i*N +: N] != '0);
      drop[i]     = run_q && valid_in[i] && !push[i];
    end
  end

  always_comb begin : p_req
    for (int unsigned j = 0; j < N; j++) begin
      req[j] = '0;
      for (int unsigned i = 0; i < N; i++) begin
        req[j][i] = nonempty[i] & rem_q[i][j];
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_arb
    switch_rr_arb #(
      .N(N)
    ) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req[j]),
      .gnt  (gnt[j])
    );
  end

  // A head pops once every target bit has been served; the next head's mask loads at that edge.
  always_comb begin : p_rem
    pop = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hit[i] = '0;
      for (int unsigned j = 0; j < N; j++) begin
        hit[i][j] = gnt[j][i];
      end
      rem_d[i] = rem_q[i] & ~hit[i];
      pop[i]   = nonempty[i] && ((rem_q[i] & ~hit[i]) == '0);
      if (pop[i]) begin
        if (cnt_q[i] > cnt_t'(1)) begin
          rem_d[i] = mem_tgt[i][rd_q[i] + AW'(1)];
        end else if (push[i]) begin
          rem_d[i] = target_in[i*N +: N];
        end
      end else if (!nonempty[i] && push[i]) begin
        rem_d[i] = target_in[i*N +: N];
      end
    end
  end

  always_comb begin : p_out
    vo_d = '0;
    for (int unsigned j = 0; j < N; j++) begin
      vo_d[j] = |gnt[j];
      so_d[j] = '0;
      to_d[j] = '0;
      do_d[j] = '0;
      if (vo_d[j]) begin
        to_d[j][j] = 1'b1;
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (gnt[j][i]) begin
          so_d[j] = so_d[j] | mem_src[i][rd_q[i]];
          do_d[j] = do_d[j] | mem_dat[i][rd_q[i]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      run_q <= 1'b0;
      vo_q  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        rd_q[i]   <= '0;
        wr_q[i]   <= '0;
        rem_q[i]  <= '0;
        drop_q[i] <= '0;
        so_q[i]   <= '0;
        to_q[i]   <= '0;
        do_q[i]   <= '0;
      end
    end else begin
      run_q <= 1'b1;
      vo_q  <= vo_d;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_q[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
        if (push[i]) wr_q[i] <= wr_q[i] + AW'(1);
        if (pop[i]) rd_q[i] <= rd_q[i] + AW'(1);
        rem_q[i] <= rem_d[i];
        if (drop[i] && drop_q[i] != CNT_MAX) drop_q[i] <= drop_q[i] + CNT_W'(1);
        so_q[i] <= so_d[i];
        to_q[i] <= to_d[i];
        do_q[i] <= do_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin : p_mem
    for (int unsigned i = 0; i < N; i++) begin
      if (push[i]) begin
        mem_src[i][wr_q[i]] <= source_in[i*N +: N];
        mem_tgt[i][wr_q[i]] <= target_in[i*N +: N];
        mem_dat[i][wr_q[i]] <= data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : p_flat
    valid_out  = vo_q;
    source_out = '0;
    target_out = '0;
    data_out   = '0;
    drop_cnt   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      source_out[i*N +: N]           = so_q[i];
      target_out[i*N +: N]           = to_q[i];
      data_out[i*DATA_W +: DATA_W]   = do_q[i];
      drop_cnt[i*CNT_W +: CNT_W]     = drop_q[i];
    end
  end

endmodule
